// File: rtl/floo_id_addr_lookup_pkg.sv
// Shared types and constants for the endpoint-ID to address-range reverse lookup.
package floo_id_lookup_pkg;

    // Lookup controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_e;

    // Width of the optional miss counter.
    localparam int unsigned MissCntWidth = 16;

    // Default widths of the lookup block; the top re-derives its own rule type from its parameters.
    localparam int unsigned DefaultIdWidth   = 8;
    localparam int unsigned DefaultAddrWidth = 48;

    // One system-address-map rule: target ID plus the [start, end) range that decodes to it.
    typedef struct packed {
        logic [DefaultIdWidth-1:0]   id;
        logic [DefaultAddrWidth-1:0] start_addr;
        logic [DefaultAddrWidth-1:0] end_addr;
    } sam_rule_t;

endpackage

// File: rtl/floo_id_addr_lookup.sv
// Reverse SAM lookup: given an endpoint ID, report the first rule decoding to it.
// Rules are scanned one per cycle, so a single comparator serves the whole table.
// Optional build macro FLOO_ID_LOOKUP_MISS_CNT_EN adds a saturating miss counter (miss_cnt_o).
//
// state | meaning
// IDLE  | ready for a request; req_id_i captured on handshake
// SCAN  | compare rule[cnt] against the captured ID, one rule per cycle
// RESP  | result presented on rsp_*; held until rsp_ready_i
module floo_id_addr_lookup
    import floo_id_lookup_pkg::*;
#(
    parameter int unsigned NumRules  = 4,
    parameter int unsigned IdWidth   = 8,
    parameter int unsigned AddrWidth = 48,
    localparam int unsigned RuleIdxW = (NumRules > 1) ? $clog2(NumRules) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [IdWidth-1:0]            req_id_i,
    input  logic [NumRules*IdWidth-1:0]   rule_id_i,
    input  logic [NumRules*AddrWidth-1:0] rule_start_i,
    input  logic [NumRules*AddrWidth-1:0] rule_end_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic                          rsp_hit_o,
    output logic [RuleIdxW-1:0]           rsp_rule_o,
    output logic [AddrWidth-1:0]          rsp_start_o,
    output logic [AddrWidth-1:0]          rsp_end_o
`ifdef FLOO_ID_LOOKUP_MISS_CNT_EN
    ,
    output logic [MissCntWidth-1:0]       miss_cnt_o
`endif
);

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] start_addr;
        logic [AddrWidth-1:0] end_addr;
    } rule_t;

    localparam logic [RuleIdxW-1:0] LastIdx = RuleIdxW'(NumRules - 1);

    if (NumRules < 1) begin : g_bad_num_rules
        $fatal(1, "floo_id_addr_lookup: NumRules must be at least 1");
    end

    rule_t rules [NumRules];

    for (genvar k = 0; k < NumRules; k++) begin : g_unpack
        assign rules[k].id         = rule_id_i[k*IdWidth +: IdWidth];
        assign rules[k].start_addr = rule_start_i[k*AddrWidth +: AddrWidth];
        assign rules[k].end_addr   = rule_end_i[k*AddrWidth +: AddrWidth];
    end

    state_e                 state_q, state_d;
    logic [RuleIdxW-1:0]    cnt_q, cnt_d;
    logic [IdWidth-1:0]     id_q, id_d;
    logic                   hit_q, hit_d;
    logic [RuleIdxW-1:0]    rule_q, rule_d;
    logic [AddrWidth-1:0]   start_q, start_d;
    logic [AddrWidth-1:0]   end_q, end_d;

    // Next-state, scan counter and result capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        hit_d   = hit_q;
        rule_d  = rule_q;
        start_d = start_q;
        end_d   = end_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    id_d    = req_id_i;
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (rules[cnt_q].id == id_q) begin
                    hit_d   = 1'b1;
                    rule_d  = cnt_q;
                    start_d = rules[cnt_q].start_addr;
                    end_d   = rules[cnt_q].end_addr;
                    state_d = RESP;
                end else if (cnt_q == LastIdx) begin
                    hit_d   = 1'b0;
                    rule_d  = '0;
                    start_d = '0;
                    end_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + RuleIdxW'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            id_q    <= '0;
            hit_q   <= 1'b0;
            rule_q  <= '0;
            start_q <= '0;
            end_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            hit_q   <= hit_d;
            rule_q  <= rule_d;
            start_q <= start_d;
            end_q   <= end_d;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_hit_o   = hit_q;
    assign rsp_rule_o  = rule_q;
    assign rsp_start_o = start_q;
    assign rsp_end_o   = end_q;

`ifdef FLOO_ID_LOOKUP_MISS_CNT_EN
    logic [MissCntWidth-1:0] miss_cnt_q;

    // Count accepted miss responses, saturating at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            miss_cnt_q <= '0;
        end else if (rsp_valid_o && rsp_ready_i && !rsp_hit_o && (miss_cnt_q != '1)) begin
            miss_cnt_q <= miss_cnt_q + MissCntWidth'(1);
        end
    end

    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
